// File: rtl/irqgen_responder.sv
// irqgen_responder: interrupt-service emulator that acknowledges IRQ generator lines in loopback.
// Latency statistics (ts, stamps, latency_last/max) are built only when IRQRESP_LATENCY_STATS_EN is defined.
module irqgen_responder #(
   parameter int C_AMOUNT_OF_IRQLINES = 16,
   parameter int C_WIDTH_OF_DELAY     = 8,
   parameter int C_WIDTH_OF_COUNT     = 16,
   parameter int C_WIDTH_OF_LATENCY   = 16
) (
   input  logic                            ACLK,
   input  logic                            reset,
   input  logic                            enable,
   input  logic [C_WIDTH_OF_DELAY-1:0]     service_delay,
   input  logic                            stats_clr,
   input  logic [C_AMOUNT_OF_IRQLINES-1:0] irq_in,
   output logic [4:0]                      irq_handled,
   output logic                            busy,
   output logic [C_WIDTH_OF_COUNT-1:0]     handled_count,
   output logic [C_WIDTH_OF_LATENCY-1:0]   latency_last,
   output logic [C_WIDTH_OF_LATENCY-1:0]   latency_max
);
   localparam int N = C_AMOUNT_OF_IRQLINES;
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_SERVICE  = 2'd1;
   localparam logic [1:0] S_ACK      = 2'd2;
   localparam logic [1:0] S_WAIT_CLR = 2'd3;

   logic [N-1:0]                  irq_r_q;
   logic [15:0]                   irq_r_ext;
   logic [1:0]                    state_q, state_d;
   logic [3:0]                    sel_q, sel_d;
   logic [3:0]                    low_idx;
   logic                          sel_line;
   logic [C_WIDTH_OF_DELAY-1:0]   cnt_q, cnt_d;
   logic [4:0]                    ack_q, ack_d;
   logic [C_WIDTH_OF_COUNT-1:0]   count_q, count_d;

   // Zero-extended copy lets a 4-bit index address any line count up to 16.
   assign irq_r_ext = 16'(irq_r_q);
   assign sel_line  = irq_r_ext[sel_q];

   always_comb begin
      low_idx = 4'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (irq_r_q[i]) low_idx = 4'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ack_d   = 5'd0;
      unique case (state_q)
         S_IDLE: begin
            if (enable && (|irq_r_q)) begin
               sel_d   = low_idx;
               cnt_d   = service_delay;
               state_d = S_SERVICE;
            end
         end
         S_SERVICE: begin
            if (!sel_line) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d = S_ACK;
               ack_d   = {sel_q, 1'b1};
            end else begin
               cnt_d = cnt_q - C_WIDTH_OF_DELAY'(1);
            end
         end
         S_ACK: state_d = S_WAIT_CLR;
         S_WAIT_CLR: begin
            if (!sel_line) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (stats_clr) begin
         count_d = '0;
      end else if ((state_q == S_ACK) && (count_q != '1)) begin
         count_d = count_q + C_WIDTH_OF_COUNT'(1);
      end
   end

   always_ff @(posedge ACLK or posedge reset) begin
      if (reset) begin
         irq_r_q <= '0;
         state_q <= S_IDLE;
         sel_q   <= 4'd0;
         cnt_q   <= '0;
         ack_q   <= 5'd0;
         count_q <= '0;
      end else begin
         irq_r_q <= irq_in;
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         count_q <= count_d;
      end
   end

   assign irq_handled   = ack_q;
   assign busy          = (state_q != S_IDLE);
   assign handled_count = count_q;

`ifdef IRQRESP_LATENCY_STATS_EN
   logic [N-1:0]                  irq_d_q;
   logic [C_WIDTH_OF_LATENCY-1:0] ts_q;
   logic [C_WIDTH_OF_LATENCY-1:0] stamp_q [N];
   logic [C_WIDTH_OF_LATENCY-1:0] lat_now;
   logic [C_WIDTH_OF_LATENCY-1:0] last_q, max_q;

   always_comb begin
      lat_now = '0;
      for (int i = 0; i < N; i++) begin
         if (4'(i) == sel_q) lat_now = ts_q - stamp_q[i];
      end
   end

   // A new ACK value beats a coincident clear for latency_last only.
   always_ff @(posedge ACLK or posedge reset) begin
      if (reset) begin
         irq_d_q <= '0;
         ts_q    <= '0;
         last_q  <= '0;
         max_q   <= '0;
         for (int i = 0; i < N; i++) stamp_q[i] <= '0;
      end else begin
         irq_d_q <= irq_r_q;
         ts_q    <= ts_q + C_WIDTH_OF_LATENCY'(1);
         for (int i = 0; i < N; i++) begin
            if (irq_r_q[i] && !irq_d_q[i]) stamp_q[i] <= ts_q;
         end
         if (state_q == S_ACK) last_q <= lat_now;
         else if (stats_clr)   last_q <= '0;
         if (stats_clr) max_q <= '0;
         else if ((state_q == S_ACK) && (lat_now > max_q)) max_q <= lat_now;
      end
   end

   assign latency_last = last_q;
   assign latency_max  = max_q;
`else
   assign latency_last = '0;
   assign latency_max  = '0;
`endif
endmodule
